// File: rtl/find_multi_points_param.sv
// Streaming multi-blob centroid finder: clusters foreground pixels into N_POINTS
// bounding-box slots per frame, then divides each slot's sums by its pixel count.
module find_multi_points_param #(
  parameter int N_POINTS   = 4,
  parameter int CW         = 16,
  parameter int CNT_W      = 20,
  parameter int MERGE_DIST = 2,
  parameter int MIN_PIXELS = 1,
  localparam int SUM_W     = CW + CNT_W
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   VGA_HS,
  input  logic                   VGA_VS,
  input  logic                   BINARY_FLAG,
  input  logic [CW-1:0]          H_CNT,
  input  logic [CW-1:0]          V_CNT,
  output logic [N_POINTS*CW-1:0] o_POINTS_H,
  output logic [N_POINTS*CW-1:0] o_POINTS_V,
  output logic [3:0]             o_POINTS_NUM,
  output logic                   o_OVERFLOW,
  output logic                   o_FRAME_DONE,
  output logic                   o_BUSY
);

  localparam int IDX_W  = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int STEP_W = $clog2(SUM_W + 1);
  localparam int CWX    = CW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_PUBLISH} state_t;

  typedef struct packed {
    logic             used;
    logic [CW-1:0]    min_h;
    logic [CW-1:0]    max_h;
    logic [CW-1:0]    max_v;
    logic [SUM_W-1:0] sum_h;
    logic [SUM_W-1:0] sum_v;
    logic [CNT_W-1:0] cnt;
  } slot_t;

  typedef struct packed {
    logic [CNT_W-1:0] rem;
    logic [SUM_W-1:0] quo;
  } div_t;

  // One restoring-division step: dividend bits shift out of quo's MSB while
  // quotient bits shift into its LSB, so after SUM_W steps quo is the quotient.
  function automatic div_t restore_step(input logic [CNT_W-1:0] rem,
                                        input logic [SUM_W-1:0] quo,
                                        input logic [CNT_W-1:0] d);
    logic [CNT_W:0] trial;
    div_t           res;
    trial   = {rem, quo[SUM_W-1]};
    res.quo = {quo[SUM_W-2:0], 1'b0};
    if (trial >= {1'b0, d}) begin
      trial      = trial - {1'b0, d};
      res.quo[0] = 1'b1;
    end
    res.rem = trial[CNT_W-1:0];
    return res;
  endfunction

  state_t               state;
  logic                 vs_d;
  slot_t                slots [N_POINTS];
  logic                 ovf_acc;
  logic [IDX_W-1:0]     div_idx;
  logic                 div_run;
  logic [STEP_W-1:0]    step_cnt;
  logic [CNT_W-1:0]     rem_h, rem_v;
  logic [SUM_W-1:0]     quo_h, quo_v;
  logic [N_POINTS*CW-1:0] shadow_h, shadow_v;
  logic [3:0]           valid_cnt;

  logic vs_rise, vs_fall, pix_q;
  assign vs_rise = VGA_VS & ~vs_d;
  assign vs_fall = ~VGA_VS & vs_d;
  assign pix_q   = BINARY_FLAG & VGA_HS & VGA_VS;

  // Per-slot match window, free flag and publish eligibility.
  logic [N_POINTS-1:0] hit, free_s, slot_ok;

  for (genvar k = 0; k < N_POINTS; k++) begin : g_match
    logic [CW:0] lo, hi, vlim;
    assign lo   = (slots[k].min_h >= CW'(MERGE_DIST))
                  ? {1'b0, slots[k].min_h - CW'(MERGE_DIST)} : '0;
    assign hi   = {1'b0, slots[k].max_h} + CWX'(MERGE_DIST);
    assign vlim = {1'b0, slots[k].max_v} + CWX'(MERGE_DIST);
    assign hit[k] = slots[k].used && ({1'b0, H_CNT} >= lo) &&
                    ({1'b0, H_CNT} <= hi) && ({1'b0, V_CNT} <= vlim);
    assign free_s[k]  = ~slots[k].used;
    assign slot_ok[k] = slots[k].used && (slots[k].cnt >= CNT_W'(MIN_PIXELS));
  end

  logic [IDX_W-1:0] hit_idx, free_idx;
  slot_t            merged, fresh;

  // NOTE: every variable driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int k = N_POINTS - 1; k >= 0; k--) begin
      if (hit[k])    hit_idx  = IDX_W'(k);
      if (free_s[k]) free_idx = IDX_W'(k);
    end

    merged = slots[hit_idx];
    if (H_CNT < merged.min_h) merged.min_h = H_CNT;
    if (H_CNT > merged.max_h) merged.max_h = H_CNT;
    if (V_CNT > merged.max_v) merged.max_v = V_CNT;
    // Once the count saturates the sums freeze, so the centroid stays meaningful.
    if (merged.cnt != '1) begin
      merged.cnt   = merged.cnt + 1'b1;
      merged.sum_h = merged.sum_h + SUM_W'(H_CNT);
      merged.sum_v = merged.sum_v + SUM_W'(V_CNT);
    end

    fresh       = '0;
    fresh.used  = 1'b1;
    fresh.min_h = H_CNT;
    fresh.max_h = H_CNT;
    fresh.max_v = V_CNT;
    fresh.sum_h = SUM_W'(H_CNT);
    fresh.sum_v = SUM_W'(V_CNT);
    fresh.cnt   = CNT_W'(1);
  end

  // Divider datapath: the first cycle of a slot seeds from its sums directly.
  slot_t cur;
  div_t  nxt_h, nxt_v;
  assign cur   = slots[div_idx];
  assign nxt_h = restore_step(div_run ? rem_h : '0, div_run ? quo_h : cur.sum_h, cur.cnt);
  assign nxt_v = restore_step(div_run ? rem_v : '0, div_run ? quo_v : cur.sum_v, cur.cnt);

  logic last_idx;
  assign last_idx = (div_idx == IDX_W'(N_POINTS - 1));

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, matching the hardware it describes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
      // vs_d resets high: a frame already in progress at reset release is not
      // mistaken for a rising edge and is skipped until the next real one.
      vs_d  <= 1'b1;
      // NOTE: the slot array is small register state, so it is reset explicitly
      // rather than left to power-up values like a RAM would be.
      for (int k = 0; k < N_POINTS; k++) slots[k] <= '0;
      ovf_acc      <= 1'b0;
      div_idx      <= '0;
      div_run      <= 1'b0;
      step_cnt     <= '0;
      rem_h        <= '0;
      rem_v        <= '0;
      quo_h        <= '0;
      quo_v        <= '0;
      shadow_h     <= '0;
      shadow_v     <= '0;
      valid_cnt    <= '0;
      o_POINTS_H   <= '0;
      o_POINTS_V   <= '0;
      o_POINTS_NUM <= '0;
      o_OVERFLOW   <= 1'b0;
      o_FRAME_DONE <= 1'b0;
      o_BUSY       <= 1'b0;
    end else begin
      vs_d         <= VGA_VS;
      o_FRAME_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vs_rise) begin
            for (int k = 0; k < N_POINTS; k++) slots[k] <= '0;
            ovf_acc <= 1'b0;
            state   <= S_ACCUM;
            o_BUSY  <= 1'b1;
          end
        end

        S_ACCUM: begin
          if (vs_fall) begin
            state     <= S_DIVIDE;
            div_idx   <= '0;
            div_run   <= 1'b0;
            step_cnt  <= '0;
            shadow_h  <= '0;
            shadow_v  <= '0;
            valid_cnt <= '0;
          end else if (pix_q) begin
            if (|hit)         slots[hit_idx]  <= merged;
            else if (|free_s) slots[free_idx] <= fresh;
            else              ovf_acc         <= 1'b1;
          end
        end

        S_DIVIDE: begin
          if (!div_run && !slot_ok[div_idx]) begin
            if (last_idx) state <= S_PUBLISH;
            else          div_idx <= div_idx + 1'b1;
          end else begin
            rem_h <= nxt_h.rem;
            quo_h <= nxt_h.quo;
            rem_v <= nxt_v.rem;
            quo_v <= nxt_v.quo;
            if (!div_run) begin
              div_run  <= 1'b1;
              step_cnt <= STEP_W'(1);
            end else if (step_cnt == STEP_W'(SUM_W - 1)) begin
              shadow_h[int'(valid_cnt)*CW +: CW] <= nxt_h.quo[CW-1:0];
              shadow_v[int'(valid_cnt)*CW +: CW] <= nxt_v.quo[CW-1:0];
              valid_cnt <= valid_cnt + 1'b1;
              div_run   <= 1'b0;
              step_cnt  <= '0;
              if (last_idx) state <= S_PUBLISH;
              else          div_idx <= div_idx + 1'b1;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        S_PUBLISH: begin
          o_POINTS_H   <= shadow_h;
          o_POINTS_V   <= shadow_v;
          o_POINTS_NUM <= valid_cnt;
          o_OVERFLOW   <= ovf_acc;
          o_FRAME_DONE <= 1'b1;
          o_BUSY       <= 1'b0;
          state        <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_multi_points_param.sv
// Directed bench for find_multi_points_param: 10x10 frames with hand-computed
// centroids, latencies, overflow, MIN_PIXELS filtering, ignored frames and reset.
module tb_find_multi_points_param;

  localparam int CW = 16;
  localparam int NP = 4;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          VGA_HS, VGA_VS, BINARY_FLAG;
  logic [CW-1:0] H_CNT, V_CNT;

  logic [NP*CW-1:0] ph, pv, ph_mp, pv_mp;
  logic [3:0]       num, num_mp;
  logic             ovf, done, busy, ovf_mp, done_mp, busy_mp;

  find_multi_points_param dut (
    .CLK(CLK), .RESET_N(RESET_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .BINARY_FLAG(BINARY_FLAG), .H_CNT(H_CNT), .V_CNT(V_CNT),
    .o_POINTS_H(ph), .o_POINTS_V(pv), .o_POINTS_NUM(num),
    .o_OVERFLOW(ovf), .o_FRAME_DONE(done), .o_BUSY(busy)
  );

  find_multi_points_param #(.MIN_PIXELS(2)) dut_mp (
    .CLK(CLK), .RESET_N(RESET_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .BINARY_FLAG(BINARY_FLAG), .H_CNT(H_CNT), .V_CNT(V_CNT),
    .o_POINTS_H(ph_mp), .o_POINTS_V(pv_mp), .o_POINTS_NUM(num_mp),
    .o_OVERFLOW(ovf_mp), .o_FRAME_DONE(done_mp), .o_BUSY(busy_mp)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge CLK) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic [99:0]    pix;
    logic [3:0]     num;
    logic [NP*CW-1:0] ph;
    logic [NP*CW-1:0] pv;
    logic           ovf;
    int             lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [99:0] px(input int h, input int v);
    logic [99:0] r;
    r = '0;
    r[v*10 + h] = 1'b1;
    return r;
  endfunction

  task automatic drive_lines(input logic [99:0] pix);
    for (int v = 0; v < 10; v++) begin
      for (int h = 0; h < 10; h++) begin
        @(negedge CLK);
        VGA_HS = 1'b1; H_CNT = CW'(h); V_CNT = CW'(v); BINARY_FLAG = pix[v*10 + h];
      end
      @(negedge CLK);
      VGA_HS = 1'b0; BINARY_FLAG = 1'b0; H_CNT = '0;
      @(negedge CLK);
    end
  endtask

  task automatic start_frame();
    @(negedge CLK);
    VGA_VS = 1'b1; VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_frame();
    @(negedge CLK);
    VGA_VS = 1'b0; VGA_HS = 1'b0; BINARY_FLAG = 1'b0;
  endtask

  // Counts negedges from the VS fall until FRAME_DONE is seen, bounded.
  task automatic wait_done(output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge CLK);
      lat++;
      if (done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    bit found;
    int lat, d0;
    d0 = done_cnt;
    start_frame();
    drive_lines(v.pix);
    check($sformatf("v%0d_busy_accum", idx), 64'(busy), 64'd1);
    end_frame();
    wait_done(found, lat);
    check($sformatf("v%0d_done_seen", idx), 64'(found), 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_num", idx), 64'(num), 64'(v.num));
    check($sformatf("v%0d_points_h", idx), 64'(ph), 64'(v.ph));
    check($sformatf("v%0d_points_v", idx), 64'(pv), 64'(v.pv));
    check($sformatf("v%0d_overflow", idx), 64'(ovf), 64'(v.ovf));
    @(negedge CLK);
    check($sformatf("v%0d_done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d_busy_idle", idx), 64'(busy), 64'd0);
    check($sformatf("v%0d_done_pulses", idx), 64'(done_cnt - d0), 64'd1);
  endtask

  logic [99:0] blob, two_blobs, five_px, blob_lone;
  int d_before;

  initial begin
    RESET_N = 1'b0; VGA_HS = 1'b0; VGA_VS = 1'b0; BINARY_FLAG = 1'b0;
    H_CNT = '0; V_CNT = '0;

    blob      = px(2,2) | px(3,2) | px(2,3) | px(3,3);
    two_blobs = px(1,5) | px(2,5) | px(3,5) | px(8,8);
    five_px   = px(0,0) | px(4,0) | px(8,0) | px(0,4) | px(4,8);
    blob_lone = blob | px(8,8);

    // sums 10/4 -> (2,2); one valid slot: 1 + 36 + 3 + 1
    vecs[0] = '{pix: blob, num: 4'd1, ph: {16'd0, 16'd0, 16'd0, 16'd2},
                pv: {16'd0, 16'd0, 16'd0, 16'd2}, ovf: 1'b0, lat: 41};
    // (6/3, 15/3) = (2,5) and (8,8); two valid slots: 1 + 72 + 2 + 1
    vecs[1] = '{pix: two_blobs, num: 4'd2, ph: {16'd0, 16'd0, 16'd8, 16'd2},
                pv: {16'd0, 16'd0, 16'd8, 16'd5}, ovf: 1'b0, lat: 76};
    // (4,8) finds no slot; four valid slots: 1 + 144 + 1
    vecs[2] = '{pix: five_px, num: 4'd4, ph: {16'd0, 16'd8, 16'd4, 16'd0},
                pv: {16'd4, 16'd0, 16'd0, 16'd0}, ovf: 1'b1, lat: 146};
    vecs[3] = vecs[0];
    vecs[4] = '{pix: blob_lone, num: 4'd2, ph: {16'd0, 16'd0, 16'd8, 16'd2},
                pv: {16'd0, 16'd0, 16'd8, 16'd2}, ovf: 1'b0, lat: 76};

    repeat (3) @(negedge CLK);
    check("reset_num", 64'(num), 64'd0);
    check("reset_points_h", 64'(ph), 64'd0);
    check("reset_points_v", 64'(pv), 64'd0);
    check("reset_ovf_done_busy", {61'd0, ovf, done, busy}, 64'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 5; i++) apply_vec(vecs[i], i);

    // Same blob+lone frame through the MIN_PIXELS=2 instance: lone pixel dropped.
    check("mp_num", 64'(num_mp), 64'd1);
    check("mp_points_h", 64'(ph_mp), 64'({16'd0, 16'd0, 16'd0, 16'd2}));
    check("mp_points_v", 64'(pv_mp), 64'({16'd0, 16'd0, 16'd0, 16'd2}));

    // VS re-asserted one cycle after the fall: that second frame is ignored.
    d_before = done_cnt;
    start_frame();
    drive_lines(px(5,5));
    end_frame();
    @(negedge CLK);
    VGA_VS = 1'b1;
    drive_lines(blob);
    end_frame();
    repeat (200) @(negedge CLK);
    check("ign_done_pulses", 64'(done_cnt - d_before), 64'd1);
    check("ign_num", 64'(num), 64'd1);
    check("ign_points_h", 64'(ph), 64'({16'd0, 16'd0, 16'd0, 16'd5}));
    check("ign_points_v", 64'(pv), 64'({16'd0, 16'd0, 16'd0, 16'd5}));
    check("ign_busy", 64'(busy), 64'd0);
    apply_vec(vecs[0], 5);

    // Reset pulsed mid-ACCUM clears outputs at once and suppresses that frame.
    start_frame();
    drive_lines(blob);
    check("rst_busy_before", 64'(busy), 64'd1);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("rst_num", 64'(num), 64'd0);
    check("rst_points", 64'(ph | pv), 64'd0);
    check("rst_ovf_done_busy", {61'd0, ovf, done, busy}, 64'd0);
    d_before = done_cnt;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    drive_lines(blob);
    end_frame();
    repeat (100) @(negedge CLK);
    check("rst_no_done", 64'(done_cnt - d_before), 64'd0);
    check("rst_busy_after", 64'(busy), 64'd0);
    check("rst_num_held", 64'(num), 64'd0);
    apply_vec(vecs[1], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/find_multi_points_param.md
Name: find_multi_points_param

Overview:
- Streaming multi-blob centroid finder for the binarised camera pixel stream. It is the parametrised successor of the fixed 4-point finder.
- Foreground pixels are clustered into up to N_POINTS slots during the active frame. At frame end, each slot's pixel-weighted centroid is computed with a serial divider.
- Results are published as compacted, frame-stable coordinate buses for the downstream marker/overlay logic.

Parameters:
- N_POINTS, 4, number of blob slots (1..8)
- CW, 16, width of H_CNT, V_CNT and output coordinates
- CNT_W, 20, width of per-slot pixel counter; saturates at all-ones
- MERGE_DIST, 2, pixel distance for joining a slot's bounding box
- MIN_PIXELS, 1, slots with count < MIN_PIXELS are discarded at publish
- SUM_W, CW+CNT_W, width of per-slot coordinate sums (derived, not to be overridden)

Ports:
- CLK  in  1  pixel clock
- RESET_N  in  1  asynchronous active-low reset
- VGA_HS  in  1  line active (high)
- VGA_VS  in  1  frame active (high)
- BINARY_FLAG  in  1  foreground pixel flag, qualified by VGA_HS & VGA_VS
- H_CNT  in  CW  pixel column
- V_CNT  in  CW  pixel row
- o_POINTS_H  out  N_POINTS*CW  centroid H; slot k at bits [k*CW +: CW]
- o_POINTS_V  out  N_POINTS*CW  centroid V; same packing
- o_POINTS_NUM  out  4  number of valid published points
- o_OVERFLOW  out  1  a pixel found no slot in the last frame
- o_FRAME_DONE  out  1  one-cycle pulse when outputs update
- o_BUSY  out  1  high outside IDLE

Behaviour:
- Reset (async, RESET_N=0): state IDLE; all slot registers 0. All outputs 0, including o_POINTS_H, o_POINTS_V, NUM, OVERFLOW, FRAME_DONE and BUSY.
- VS edges: VGA_VS is registered as vs_d. Rise = VGA_VS & ~vs_d; fall = ~VGA_VS & vs_d.
- FSM IDLE: on a VS rise, clear all slots and the overflow accumulator, then go to ACCUM. Pixels present in this same cycle are not accumulated. A VS fall in IDLE is ignored.
- FSM ACCUM: a pixel is qualified when BINARY_FLAG & VGA_HS & VGA_VS.
  - A qualified pixel matches slot k if slot k is used and H lies in [minH−MERGE_DIST, maxH+MERGE_DIST]. The lower bound clamps at 0.
  - The match also requires V ≤ maxV+MERGE_DIST.
  - The lowest-index match wins. The winning slot updates minH, maxH, maxV, sumH+=H, sumV+=V and count+=1. count saturates; once count saturates, the sums hold.
  - If there is no match, the pixel allocates the lowest free slot with min=max=H and maxV=V, sums set to H and V, and count=1.
  - If there is no match and no free slot, the pixel is dropped and the overflow accumulator is set.
  - The slot update is single-cycle read-modify-write: back-to-back pixels on consecutive clocks must see the previous pixel's update.
  - Slots are never merged with each other; a U-shaped blob yields 2 points. This is documented behaviour.
  - On a VS fall, go to DIVIDE.
- FSM DIVIDE: slots are processed k=0..N_POINTS−1.
  - A slot that is unused or has count<MIN_PIXELS takes 1 cycle and is skipped.
  - Otherwise two parallel restoring dividers compute floor(sumH/count) and floor(sumV/count) in SUM_W cycles.
  - Results are written compacted in ascending slot index into shadow registers, and the valid counter is incremented.
  - Unfilled shadow positions are 0.
- FSM PUBLISH: takes 1 cycle.
  - Shadow registers are copied to o_POINTS_H, o_POINTS_V and o_POINTS_NUM; the overflow accumulator is copied to o_OVERFLOW.
  - o_FRAME_DONE=1 for this one cycle, then the FSM returns to IDLE.
- Latency: from the VS fall to o_FRAME_DONE is 1 + Σ(cycles per slot) + 1, where each slot costs SUM_W if valid, else 1.
- Outputs hold between publishes; there are no partial updates.
- A VS rise while the FSM is in DIVIDE or PUBLISH is ignored: that frame is not accumulated. The next accepted frame starts at the next VS rise seen in IDLE.
- o_BUSY is high in ACCUM, DIVIDE and PUBLISH.
- Reset mid-operation returns the block to IDLE, clears all outputs, and produces no FRAME_DONE.
- A qualified pixel arriving in the same cycle as the VS fall cannot occur (VS is low), so it is not counted.

Test Plan:
- 10x10 frame, 2x2 blob at H2–3/V2–3 → FRAME_DONE once; NUM=1; point0=(2,2) (sum 10/4); OVERFLOW=0.
- Two blobs: 3x1 at H1–3/V5 and a single pixel at H8/V8 → NUM=2; points (2,5) and (8,8) in slot order.
- Five isolated pixels at (0,0),(4,0),(8,0),(0,4),(4,8) with N_POINTS=4 → NUM=4; first four kept; OVERFLOW=1; next clean frame clears OVERFLOW.
- MIN_PIXELS=2, one 2x2 blob plus a lone pixel → NUM=1; position 1 reads 0.
- VS re-asserted 1 cycle after the VS fall (during DIVIDE) containing a blob → that frame is ignored; outputs reflect the prior frame; the next frame is processed normally.
- RESET_N pulsed low mid-ACCUM → all outputs 0 immediately; BUSY=0; no FRAME_DONE until the next full frame.
